// File: rtl/if_fetch_queue.sv
// Instruction fetch queue: issues one fetch at a time from PCin, buffers tagged words in a FWFT FIFO.
// Optional misaligned-fetch trap enabled by defining IFQ_ALIGN_CHECK_EN.
module if_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic [31:0]   PCin,
    output logic          PC_EN,
    output logic          Imem_req,
    output logic [31:0]   Imem_addr,
    input  logic          Imem_gnt,
    input  logic          Imem_rvalid,
    input  logic [31:0]   Imem_rdata,
    input  logic          Redirect,
    output logic          Inst_valid,
    output logic [31:0]   Inst,
    output logic [31:0]   Inst_PC,
    input  logic          Inst_ready,
    output logic [CW-1:0] Count,
    output logic          Fault
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   tag_q, tag_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic          fault_q, fault_d;
    logic [31:0]   inst_mem_q [DEPTH];
    logic [31:0]   pc_mem_q   [DEPTH];

    logic          slot_free;
    logic          misalign;
    logic          push;
    logic          pop;

`ifdef IFQ_ALIGN_CHECK_EN
    assign misalign = (PCin[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign slot_free  = (count_q < CW'(DEPTH));
    assign Imem_req   = !Rst && (state_q == ST_IDLE) && !Redirect && slot_free && !fault_q && !misalign;
    assign PC_EN      = Imem_req && Imem_gnt;
    assign Imem_addr  = PCin;
    assign Inst_valid = !Rst && (count_q != {CW{1'b0}});
    assign Inst       = inst_mem_q[rd_ptr_q];
    assign Inst_PC    = pc_mem_q[rd_ptr_q];
    assign Count      = count_q;
    assign Fault      = fault_q;

    // A redirect cancels both queue ports for the cycle.
    assign push = (state_q == ST_WAIT) && Imem_rvalid && !Redirect;
    assign pop  = Inst_valid && Inst_ready && !Redirect;

    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        case (state_q)
            ST_IDLE: begin
                if (PC_EN) begin
                    state_d = ST_WAIT;
                    tag_d   = PCin;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (Imem_rvalid) begin
                    state_d = ST_IDLE;
                end else if (Redirect) begin
                    state_d = ST_DROP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DROP: begin
                if (Imem_rvalid) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        fault_d  = fault_q;
        if (Redirect) begin
            count_d  = {CW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            wr_ptr_d = {AW{1'b0}};
            fault_d  = 1'b0;
        end else begin
            // Pointers wrap naturally since DEPTH is a power of two.
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if ((state_q == ST_IDLE) && slot_free && misalign) begin
                fault_d = 1'b1;
            end else begin
                fault_d = fault_q;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= ST_IDLE;
            tag_q    <= 32'd0;
            count_q  <= {CW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            wr_ptr_q <= {AW{1'b0}};
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            tag_q    <= tag_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            fault_q  <= fault_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge Clk) begin
        if (push) begin
            inst_mem_q[wr_ptr_q] <= Imem_rdata;
            pc_mem_q[wr_ptr_q]   <= tag_q;
        end
    end

endmodule
